// File: rtl/mul_issue_seq_if.sv
// Request, response and multiplier-core handshake of the RV32M MUL issue sequencer.
// The master modport is the sequencer's view; slave is the view of its surroundings.
interface mul_issue_seq_if #(
    parameter int XLEN = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [1:0]        req_op_i;
    logic [XLEN-1:0]   req_rs1_i;
    logic [XLEN-1:0]   req_rs2_i;
    logic [4:0]        req_rd_i;
    logic              mc_start_o;
    logic [XLEN-1:0]   mc_multiplicand_o;
    logic [XLEN-1:0]   mc_multiplier_o;
    logic [2*XLEN-1:0] mc_product_i;
    logic              mc_done_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [XLEN-1:0]   rsp_data_o;
    logic [4:0]        rsp_rd_o;

    modport master (
        input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_rd_i,
        output req_ready_o,
        output mc_start_o, mc_multiplicand_o, mc_multiplier_o,
        input  mc_product_i, mc_done_i,
        output rsp_valid_o, rsp_data_o, rsp_rd_o,
        input  rsp_ready_i
    );

    modport slave (
        output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_rd_i,
        input  req_ready_o,
        input  mc_start_o, mc_multiplicand_o, mc_multiplier_o,
        output mc_product_i, mc_done_i,
        input  rsp_valid_o, rsp_data_o, rsp_rd_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/mul_issue_seq.sv
// EX-stage sequencer for MUL/MULH/MULHSU/MULHU around an iterative unsigned shift-add core:
// sign-magnitude conversion, launch, two's-complement fixup, half select and a one-entry result cache.
module mul_issue_seq #(
    parameter int XLEN     = 32,
    parameter bit REUSE_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    output logic            busy_o,
    mul_issue_seq_if.master bus
);
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_FIXUP  = 3'd3,
        S_RESP   = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_rs2;
    logic [1:0]        r_op;
    logic [4:0]        r_rd;
    logic              r_neg;
    logic              r_hit;
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [2*XLEN-1:0] r_prod;

    logic              r_start;
    logic              r_rsp_valid;
    logic [XLEN-1:0]   r_rsp_data;
    logic [4:0]        r_rsp_rd;
    logic              r_busy;

    logic              r_cache_vld;
    logic [XLEN-1:0]   r_key_rs1;
    logic [XLEN-1:0]   r_key_rs2;
    logic [1:0]        r_key_op;
    logic [2*XLEN-1:0] r_cache_val;

    logic              w_accept;
    logic              w_hit;
    logic              w_neg_a;
    logic              w_neg_b;
    logic              w_launch;
    logic              w_prod_load;
    logic              w_rsp_load;
    logic              w_cache_wr;
    logic [2*XLEN-1:0] w_p64;

    // Two's-complement magnitude; the most negative value maps onto itself, read as unsigned.
    function automatic logic [XLEN-1:0] f_mag(input logic [XLEN-1:0] x, input logic neg);
        logic [XLEN-1:0] res;
        if (neg) begin
            res = ~x + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            res = x;
        end
        return res;
    endfunction

    assign w_neg_a = bus.req_rs1_i[XLEN-1] &
                     ((bus.req_op_i == OP_MULH) | (bus.req_op_i == OP_MULHSU));
    assign w_neg_b = bus.req_rs2_i[XLEN-1] & (bus.req_op_i == OP_MULH);

    // A cached low half is valid for MUL whatever signedness produced it; high halves need the same op.
    assign w_hit = (REUSE_EN == 1'b1) && r_cache_vld &&
                   (bus.req_rs1_i == r_key_rs1) && (bus.req_rs2_i == r_key_rs2) &&
                   ((bus.req_op_i == OP_MUL) || (bus.req_op_i == r_key_op));

    assign bus.req_ready_o       = (r_state == S_IDLE) & ~flush_i;
    assign w_accept              = bus.req_valid_i & bus.req_ready_o;
    assign bus.mc_start_o        = r_start;
    assign bus.mc_multiplicand_o = r_mcand;
    assign bus.mc_multiplier_o   = r_mplier;
    assign bus.rsp_valid_o       = r_rsp_valid;
    assign bus.rsp_data_o        = r_rsp_data;
    assign bus.rsp_rd_o          = r_rsp_rd;
    assign busy_o                = r_busy;

    // Signed fixup of the core product; cached values are already final.
    always_comb begin
        w_p64 = r_prod;
        if (!r_hit && r_neg) begin
            w_p64 = ~r_prod + {{(2*XLEN-1){1'b0}}, 1'b1};
        end else begin
            w_p64 = r_prod;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_prod_load = 1'b0;
        w_rsp_load  = 1'b0;
        w_cache_wr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_hit) begin
                        w_state_nxt = S_FIXUP;
                        w_prod_load = 1'b1;
                    end else begin
                        w_state_nxt = S_LAUNCH;
                        w_launch    = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LAUNCH: begin
                if (flush_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    if (bus.mc_done_i) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end else if (bus.mc_done_i) begin
                    w_state_nxt = S_FIXUP;
                    w_prod_load = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_FIXUP: begin
                if (flush_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                    w_rsp_load  = 1'b1;
                    w_cache_wr  = ~r_hit;
                end
            end
            S_RESP: begin
                if (flush_i || bus.rsp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            S_DRAIN: begin
                if (bus.mc_done_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request capture; operand magnitudes stay on the core ports until the next accept.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rs1    <= {XLEN{1'b0}};
            r_rs2    <= {XLEN{1'b0}};
            r_op     <= 2'b00;
            r_rd     <= 5'd0;
            r_neg    <= 1'b0;
            r_hit    <= 1'b0;
            r_mcand  <= {XLEN{1'b0}};
            r_mplier <= {XLEN{1'b0}};
        end else if (w_accept) begin
            r_rs1    <= bus.req_rs1_i;
            r_rs2    <= bus.req_rs2_i;
            r_op     <= bus.req_op_i;
            r_rd     <= bus.req_rd_i;
            r_neg    <= w_neg_a ^ w_neg_b;
            r_hit    <= w_hit;
            r_mcand  <= f_mag(bus.req_rs1_i, w_neg_a);
            r_mplier <= f_mag(bus.req_rs2_i, w_neg_b);
        end
    end

    // Product holding register: cache value on a hit, core result on completion.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_prod <= {(2*XLEN){1'b0}};
        end else if (w_prod_load) begin
            if (r_state == S_IDLE) begin
                r_prod <= r_cache_val;
            end else begin
                r_prod <= bus.mc_product_i;
            end
        end
    end

    // Registered outputs toward the core, writeback and the pipeline.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_start     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= {XLEN{1'b0}};
            r_rsp_rd    <= 5'd0;
            r_busy      <= 1'b0;
        end else begin
            r_start     <= w_launch;
            r_rsp_valid <= (w_state_nxt == S_RESP);
            r_busy      <= (w_state_nxt != S_IDLE);
            if (w_rsp_load) begin
                r_rsp_data <= (r_op == OP_MUL) ? w_p64[XLEN-1:0] : w_p64[2*XLEN-1:XLEN];
                r_rsp_rd   <= r_rd;
            end
        end
    end

    // One-entry result cache, written only by a completed, unflushed miss.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cache_vld <= 1'b0;
            r_key_rs1   <= {XLEN{1'b0}};
            r_key_rs2   <= {XLEN{1'b0}};
            r_key_op    <= 2'b00;
            r_cache_val <= {(2*XLEN){1'b0}};
        end else if (w_cache_wr) begin
            r_cache_vld <= 1'b1;
            r_key_rs1   <= r_rs1;
            r_key_rs2   <= r_rs2;
            r_key_op    <= r_op;
            r_cache_val <= w_p64;
        end
    end
endmodule

// File: tb/tb_mul_issue_seq.sv
// Randomized self-checking bench for mul_issue_seq: a cached and an uncached instance, each with a
// behavioural multiplier core, compared against signed/unsigned 64-bit arithmetic and a cache model.
module tb_mul_issue_seq;
    localparam int XLEN     = 32;
    // Core raises done 31 cycles after the cycle carrying mc_start_o.
    localparam int CORE_CNT = 30;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic [1:0]  req_valid;
    logic [1:0]  req_op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rsp_ready;

    logic [1:0]  req_ready;
    logic [1:0]  mc_start;
    logic [1:0]  mc_done;
    logic [1:0]  rsp_valid;
    logic [1:0]  busy;
    logic [31:0] mcand [2];
    logic [31:0] mplier [2];
    logic [31:0] rsp_data [2];
    logic [4:0]  rsp_rd [2];
    logic [63:0] mc_prod [2];
    int          core_cnt [2];
    logic [63:0] core_prod [2];
    int          start_cnt [2] = '{0, 0};

    int          checks = 0;
    int          errors = 0;

    logic        c_vld;
    logic [31:0] c_a;
    logic [31:0] c_b;
    logic [1:0]  c_op;

    mul_issue_seq_if #(.XLEN(XLEN)) bus0 ();
    mul_issue_seq_if #(.XLEN(XLEN)) bus1 ();

    mul_issue_seq #(.XLEN(XLEN), .REUSE_EN(1'b1)) u_dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .busy_o  (busy[0]),
        .bus     (bus0)
    );

    mul_issue_seq #(.XLEN(XLEN), .REUSE_EN(1'b0)) u_dut_nc (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .busy_o  (busy[1]),
        .bus     (bus1)
    );

    assign bus0.req_valid_i  = req_valid[0];
    assign bus0.req_op_i     = req_op;
    assign bus0.req_rs1_i    = rs1;
    assign bus0.req_rs2_i    = rs2;
    assign bus0.req_rd_i     = rd;
    assign bus0.rsp_ready_i  = rsp_ready;
    assign bus0.mc_done_i    = mc_done[0];
    assign bus0.mc_product_i = mc_prod[0];
    assign bus1.req_valid_i  = req_valid[1];
    assign bus1.req_op_i     = req_op;
    assign bus1.req_rs1_i    = rs1;
    assign bus1.req_rs2_i    = rs2;
    assign bus1.req_rd_i     = rd;
    assign bus1.rsp_ready_i  = rsp_ready;
    assign bus1.mc_done_i    = mc_done[1];
    assign bus1.mc_product_i = mc_prod[1];

    assign req_ready[0] = bus0.req_ready_o;
    assign req_ready[1] = bus1.req_ready_o;
    assign mc_start[0]  = bus0.mc_start_o;
    assign mc_start[1]  = bus1.mc_start_o;
    assign rsp_valid[0] = bus0.rsp_valid_o;
    assign rsp_valid[1] = bus1.rsp_valid_o;
    assign mcand[0]     = bus0.mc_multiplicand_o;
    assign mcand[1]     = bus1.mc_multiplicand_o;
    assign mplier[0]    = bus0.mc_multiplier_o;
    assign mplier[1]    = bus1.mc_multiplier_o;
    assign rsp_data[0]  = bus0.rsp_data_o;
    assign rsp_data[1]  = bus1.rsp_data_o;
    assign rsp_rd[0]    = bus0.rsp_rd_o;
    assign rsp_rd[1]    = bus1.rsp_rd_o;

    always #5 clk_i = ~clk_i;

    // Behavioural unsigned multiplier cores, one per instance, plus launch counters.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 2; i++) begin
                core_cnt[i] <= 0;
                mc_done[i]  <= 1'b0;
                mc_prod[i]  <= 64'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                mc_done[i] <= 1'b0;
                if (mc_start[i] === 1'b1) begin
                    core_cnt[i]  <= CORE_CNT;
                    core_prod[i] <= {32'd0, mcand[i]} * {32'd0, mplier[i]};
                    start_cnt[i] <= start_cnt[i] + 1;
                end else if (core_cnt[i] == 1) begin
                    core_cnt[i] <= 0;
                    mc_done[i]  <= 1'b1;
                    mc_prod[i]  <= core_prod[i];
                end else if (core_cnt[i] > 1) begin
                    core_cnt[i] <= core_cnt[i] - 1;
                end
            end
        end
    end

    // RV32M result from sign/zero-extended 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic do_req(input int sel, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input int stall, input string name);
        logic [31:0] exp_data;
        bit          exp_hit;
        int          exp_lat;
        int          s0;
        int          lat;
        int          cyc;
        exp_data = ref_result(op, a, b);
        exp_hit  = (sel == 0) && c_vld && (a == c_a) && (b == c_b) && ((op == 2'b00) || (op == c_op));
        exp_lat  = exp_hit ? 2 : 34;
        req_op = op; rs1 = a; rs2 = b; rd = tag; rsp_ready = 1'b0;
        req_valid[sel] = 1'b1;
        #1;
        checks++;
        if (req_ready[sel] !== 1'b1) begin
            errors++; $display("FAIL %s req_ready before accept: got %b want 1", name, req_ready[sel]);
        end
        s0 = start_cnt[sel];
        @(posedge clk_i); #1;
        req_valid[sel] = 1'b0;
        cyc = 1;
        lat = -1;
        while (lat < 0 && cyc < 100) begin
            if (rsp_valid[sel] === 1'b1) begin
                lat = cyc;
            end else begin
                @(posedge clk_i); #1;
                cyc++;
            end
        end
        checks++;
        if (lat != exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        if (lat < 0) return;
        checks++;
        if (rsp_data[sel] !== exp_data) begin
            errors++; $display("FAIL %s data: got %h want %h", name, rsp_data[sel], exp_data);
        end
        checks++;
        if (rsp_rd[sel] !== tag) begin
            errors++; $display("FAIL %s rd: got %0d want %0d", name, rsp_rd[sel], tag);
        end
        for (int k = 0; k < stall; k++) begin
            @(posedge clk_i); #1;
            checks++;
            if (rsp_valid[sel] !== 1'b1 || rsp_data[sel] !== exp_data || rsp_rd[sel] !== tag ||
                req_ready[sel] !== 1'b0 || busy[sel] !== 1'b1) begin
                errors++;
                $display("FAIL %s stall hold: got v=%b d=%h rd=%0d rdy=%b busy=%b want v=1 d=%h rd=%0d rdy=0 busy=1",
                         name, rsp_valid[sel], rsp_data[sel], rsp_rd[sel], req_ready[sel], busy[sel], exp_data, tag);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid[sel] !== 1'b0 || busy[sel] !== 1'b0 || req_ready[sel] !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got v=%b busy=%b rdy=%b want v=0 busy=0 rdy=1",
                     name, rsp_valid[sel], busy[sel], req_ready[sel]);
        end
        checks++;
        if (start_cnt[sel] - s0 != (exp_hit ? 0 : 1)) begin
            errors++; $display("FAIL %s launches: got %0d want %0d", name, start_cnt[sel] - s0, exp_hit ? 0 : 1);
        end
        if (sel == 0 && !exp_hit) begin
            c_vld = 1'b1; c_a = a; c_b = b; c_op = op;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (busy !== 2'b00 || rsp_valid !== 2'b00 || mc_start !== 2'b00 || rsp_data[0] !== 32'd0 ||
            rsp_rd[0] !== 5'd0 || mcand[0] !== 32'd0 || mplier[0] !== 32'd0) begin
            errors++;
            $display("FAIL reset outputs: got busy=%b v=%b st=%b d=%h rd=%0d a=%h b=%h want all 0",
                     busy, rsp_valid, mc_start, rsp_data[0], rsp_rd[0], mcand[0], mplier[0]);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b11) begin
            errors++; $display("FAIL reset req_ready: got %b want 11", req_ready);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_mul_basic();
        do_req(0, 2'b00, 32'd7, 32'hFFFF_FFFD, 5'd3, 0, "mul_basic");
    endtask

    task automatic test_boundary();
        do_req(0, 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd4, 0, "mulh_min");
        do_req(0, 2'b11, 32'h8000_0000, 32'h8000_0000, 5'd5, 0, "mulhu_min");
        do_req(0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0, "mulhsu_ones");
        do_req(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0, "mulhu_ones");
        do_req(0, 2'b01, 32'd0, 32'h8000_0001, 5'd8, 0, "mulh_zero_neg");
    endtask

    task automatic test_reuse();
        do_req(0, 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'd10, 0, "reuse_mulh");
        do_req(0, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11, 0, "reuse_mul_hit");
        do_req(0, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12, 0, "reuse_mulhu_miss");
        do_req(0, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13, 0, "reuse_mulhu_hit");
    endtask

    task automatic test_no_reuse();
        do_req(1, 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14, 0, "noreuse_mulh");
        do_req(1, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, 0, "noreuse_mul");
    endtask

    task automatic test_stall();
        do_req(0, 2'b10, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd16, 5, "stall_miss");
        do_req(0, 2'b00, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd17, 5, "stall_hit");
    endtask

    task automatic test_flush_wait();
        int s0;
        bit seen;
        req_op = 2'b11; rs1 = 32'h0000_BEEF; rs2 = 32'hCAFE_0001; rd = 5'd20;
        req_valid[0] = 1'b1;
        s0 = start_cnt[0];
        @(posedge clk_i); #1;
        req_valid[0] = 1'b0;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 33; cyc++) begin
            flush_i = (cyc == 10);
            #1;
            if (rsp_valid[0] === 1'b1) seen = 1'b1;
            if (cyc >= 11 && cyc <= 32) begin
                checks++;
                if (req_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL flush_drain cycle %0d: got rdy=%b busy=%b want rdy=0 busy=1", cyc, req_ready[0], busy[0]);
                end
            end
            if (cyc < 33) begin
                @(posedge clk_i); #1;
            end
        end
        checks++;
        if (req_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL flush_idle: got rdy=%b busy=%b want rdy=1 busy=0", req_ready[0], busy[0]);
        end
        checks++;
        if (seen || start_cnt[0] - s0 != 1) begin
            errors++; $display("FAIL flush_resp: got rsp_seen=%b launches=%0d want rsp_seen=0 launches=1", seen, start_cnt[0] - s0);
        end
        do_req(0, 2'b11, 32'h0000_BEEF, 32'hCAFE_0001, 5'd21, 0, "after_flush");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        a = 32'd0; b = 32'd0;
        for (int n = 0; n < 20; n++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 || n == 0) begin
                case ($urandom_range(0, 3))
                    0: a = 32'h8000_0000;
                    1: a = 32'hFFFF_FFFF;
                    2: a = 32'd0;
                    default: a = $urandom;
                endcase
                b = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : $urandom;
            end
            do_req(0, op, a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 2), "random");
        end
    endtask

    task automatic test_reset_midwait();
        logic [31:0] pa;
        logic [31:0] pb;
        logic [1:0]  pop;
        pa = c_a; pb = c_b; pop = c_op;
        req_op = 2'b00; rs1 = pa ^ 32'h0000_0001; rs2 = pb; rd = 5'd30;
        req_valid[0] = 1'b1;
        @(posedge clk_i); #1;
        req_valid[0] = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        checks++;
        if (busy[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || mc_start[0] !== 1'b0 || rsp_data[0] !== 32'd0 ||
            rsp_rd[0] !== 5'd0 || mcand[0] !== 32'd0 || mplier[0] !== 32'd0) begin
            errors++;
            $display("FAIL reset_midwait outputs: got busy=%b v=%b st=%b d=%h rd=%0d a=%h b=%h want all 0",
                     busy[0], rsp_valid[0], mc_start[0], rsp_data[0], rsp_rd[0], mcand[0], mplier[0]);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        c_vld = 1'b0;
        @(posedge clk_i); #1;
        do_req(0, pop, pa, pb, 5'd31, 0, "after_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b0; flush_i = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        req_op = 2'b00; rs1 = 32'd0; rs2 = 32'd0; rd = 5'd0;
        c_vld = 1'b0; c_a = 32'd0; c_b = 32'd0; c_op = 2'b00;
        test_reset();
        test_mul_basic();
        test_boundary();
        test_reuse();
        test_no_reuse();
        test_stall();
        test_flush_wait();
        test_random();
        test_reset_midwait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
